frontend_fetch_buffer: RTL and testbench

Fetch stage and one-entry instruction buffer directly upstream of the frontend selector. It owns the fetch PC, drives the instruction-memory address, and presents two candidates to the selector: the current fetch word (C slot, combinational from memory) and the buffered word (B slot, registered). It then applies the selector's `result`/`req` decision to advance the PC, refill or shift the buffer, and handles backend stalls and redirects.

---
 rtl/frontend_fetch_buffer.sv | 142 ++++++++++++++
 tb/tb_frontend_fetch_buffer.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/frontend_fetch_buffer.sv
// frontend_fetch_buffer
//   Fetch stage plus a one-entry instruction buffer in front of the frontend
//   selector. It owns the fetch PC and drives the instruction-memory address.
//   It offers two candidates to the selector:
//     C slot - the current fetch word, combinational from memory.
//     B slot - the buffered word, registered.
//   The selector's result/req decision for cycle N is applied at edge N+1.
//
// Ports
//   clk, resetn          clock; asynchronous active-low reset
//   stall                backend hold; freezes all state
//   redirect, redirect_pc
//                        backend PC redirect; flushes both slots
//   result, req          selector decision and refill request
//   imem_addr, imem_data instruction memory (combinational read)
//   cpc, data            C slot (pc_q, imem_data)
//   bpc, bf              B slot; bf reads 0 while B is invalid
//   valid                selector output is a real instruction this cycle
//   stat_issued, stat_bubbles
//                        performance counters
//
// state | meaning
// ------+---------------------------------------------------------------
// FILL  | B slot empty; load it from the current fetch word, no emission
// RUN   | B slot valid; apply the selector decision every cycle
module frontend_fetch_buffer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic [1:0]  result,
  input  logic        req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  output logic [31:0] cpc,
  output logic [31:0] data,
  output logic [31:0] bpc,
  output logic [31:0] bf,
  output logic        valid,
  output logic [31:0] stat_issued,
  output logic [31:0] stat_bubbles
);

  // Selector decision encodings, shared with the selector. 2'b11 is unused.
  localparam logic [1:0] POP_DATA   = 2'b00;
  localparam logic [1:0] POP_BUF    = 2'b01;
  localparam logic [1:0] INSERT_NOP = 2'b10;

  typedef enum logic {
    FILL = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t      state, state_nxt;
  logic [31:0] pc_q, pc_nxt;
  logic [31:0] bpc_q, bpc_nxt;
  logic [31:0] bf_q, bf_nxt;
  logic [31:0] issued_q, issued_nxt;
  logic [31:0] bubbles_q, bubbles_nxt;
  logic        result_legal;

  assign result_legal = (result == POP_DATA) || (result == POP_BUF) ||
                        (result == INSERT_NOP);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= FILL;
      pc_q      <= RESET_PC;
      bpc_q     <= 32'h0;
      bf_q      <= 32'h0;
      issued_q  <= 32'h0;
      bubbles_q <= 32'h0;
    end else begin
      state     <= state_nxt;
      pc_q      <= pc_nxt;
      bpc_q     <= bpc_nxt;
      bf_q      <= bf_nxt;
      issued_q  <= issued_nxt;
      bubbles_q <= bubbles_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    pc_nxt      = pc_q;
    bpc_nxt     = bpc_q;
    bf_nxt      = bf_q;
    issued_nxt  = issued_q;
    bubbles_nxt = bubbles_q;

    if (redirect) begin
      // Redirect wins over stall and is not counted as an issue or bubble.
      pc_nxt    = {redirect_pc[31:2], 2'b00};
      bpc_nxt   = 32'h0;
      bf_nxt    = 32'h0;
      state_nxt = FILL;
    end else if (!stall) begin
      if (valid) issued_nxt = issued_q + 32'd1;
      else       bubbles_nxt = bubbles_q + 32'd1;

      case (state)
        FILL: begin
          bpc_nxt   = pc_q;
          bf_nxt    = imem_data;
          pc_nxt    = pc_q + 32'd4;
          state_nxt = RUN;
        end
        RUN: begin
          case (result)
            // Branch in B emitted: leave a nop so the delay slot in C goes next.
            INSERT_NOP: bf_nxt = 32'h0;
            POP_BUF: begin
              bpc_nxt = pc_q;
              bf_nxt  = imem_data;
              pc_nxt  = pc_q + 32'd4;
            end
            POP_DATA: begin
              pc_nxt = pc_q + 32'd4;
              // Nop in B was dropped: B must be refilled from the new fetch word.
              if (req) state_nxt = FILL;
            end
            default: ;
          endcase
        end
        default: state_nxt = FILL;
      endcase
    end
  end

  assign valid        = (state == RUN) && result_legal;
  assign imem_addr    = pc_q;
  assign cpc          = pc_q;
  assign data         = imem_data;
  assign bpc          = bpc_q;
  assign bf           = (state == RUN) ? bf_q : 32'h0;
  assign stat_issued  = issued_q;
  assign stat_bubbles = bubbles_q;

endmodule

// File: tb/tb_frontend_fetch_buffer.sv
// Directed testbench for frontend_fetch_buffer. Instruction memory returns
// address + 0x1000_0000 so every fetched word is identifiable.
module tb_frontend_fetch_buffer;

  localparam logic [1:0] POP_DATA   = 2'b00;
  localparam logic [1:0] POP_BUF    = 2'b01;
  localparam logic [1:0] INSERT_NOP = 2'b10;
  localparam logic [1:0] ILLEGAL    = 2'b11;
  localparam logic [31:0] TAG       = 32'h1000_0000;

  logic        clk = 1'b0;
  logic        resetn;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [1:0]  result;
  logic        req;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic [31:0] cpc, data, bpc, bf;
  logic        valid;
  logic [31:0] stat_issued, stat_bubbles;

  int errors = 0;
  int checks = 0;

  frontend_fetch_buffer dut (
    .clk          (clk),
    .resetn       (resetn),
    .stall        (stall),
    .redirect     (redirect),
    .redirect_pc  (redirect_pc),
    .result       (result),
    .req          (req),
    .imem_addr    (imem_addr),
    .imem_data    (imem_data),
    .cpc          (cpc),
    .data         (data),
    .bpc          (bpc),
    .bf           (bf),
    .valid        (valid),
    .stat_issued  (stat_issued),
    .stat_bubbles (stat_bubbles)
  );

  always #5 clk = ~clk;

  always_comb imem_data = imem_addr + TAG;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Full snapshot of the observable slots and counters.
  task automatic snap(input string tag, input logic [31:0] e_cpc, input logic [31:0] e_bpc,
                      input logic [31:0] e_bf, input logic e_valid,
                      input logic [31:0] e_iss, input logic [31:0] e_bub);
    chk({tag, ".cpc"}, cpc, e_cpc);
    chk({tag, ".bpc"}, bpc, e_bpc);
    chk({tag, ".bf"}, bf, e_bf);
    chk({tag, ".valid"}, {31'h0, valid}, {31'h0, e_valid});
    chk({tag, ".issued"}, stat_issued, e_iss);
    chk({tag, ".bubbles"}, stat_bubbles, e_bub);
  endtask

  initial begin
    resetn      = 1'b0;
    stall       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    result      = POP_BUF;
    req         = 1'b0;

    // Reset state, and redirect during reset is ignored.
    #12;
    chk("rst.imem_addr", imem_addr, 32'h0);
    snap("rst", 32'h0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0);
    redirect    = 1'b1;
    redirect_pc = 32'h200;
    tick();
    chk("rst_redirect.imem_addr", imem_addr, 32'h0);
    redirect = 1'b0;
    #1 resetn = 1'b1;
    #1;
    // Cycle 0: FILL, no emission even though selector says POP_BUF.
    snap("fill0", 32'h0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0);
    chk("fill0.data", data, TAG);

    // Straight-line code with POP_BUF.
    tick(); snap("run1", 32'h4, 32'h0, TAG, 1'b1, 32'd0, 32'd1);
    tick(); snap("run2", 32'h8, 32'h4, TAG + 32'h4, 1'b1, 32'd1, 32'd1);
    tick(); snap("run3", 32'hC, 32'h8, TAG + 32'h8, 1'b1, 32'd2, 32'd1);
    tick(); snap("run4", 32'h10, 32'hC, TAG + 32'hC, 1'b1, 32'd3, 32'd1);
    tick(); snap("run5", 32'h14, 32'h10, TAG + 32'h10, 1'b1, 32'd4, 32'd1);

    // B=0x10 is a branch.
    result = INSERT_NOP;
    #1 chk("br.valid", {31'h0, valid}, 32'h1);
    tick(); snap("nop", 32'h14, 32'h10, 32'h0, 1'b1, 32'd5, 32'd1);
    result = POP_DATA;
    req    = 1'b1;
    tick();
    result = POP_BUF;
    req    = 1'b0;
    #1 snap("refill", 32'h18, 32'h10, 32'h0, 1'b0, 32'd6, 32'd1);
    tick(); snap("reload", 32'h1C, 32'h18, TAG + 32'h18, 1'b1, 32'd6, 32'd2);
    tick(); snap("run6", 32'h20, 32'h1C, TAG + 32'h1C, 1'b1, 32'd7, 32'd2);
    tick(); snap("run7", 32'h24, 32'h20, TAG + 32'h20, 1'b1, 32'd8, 32'd2);

    // POP_DATA without req: C swapped ahead of B, B holds.
    result = POP_DATA;
    tick(); snap("swap", 32'h28, 32'h20, TAG + 32'h20, 1'b1, 32'd9, 32'd2);

    // Illegal encoding: no emission, state holds, bubble counted.
    result = ILLEGAL;
    #1 chk("illegal.valid", {31'h0, valid}, 32'h0);
    tick(); snap("illegal", 32'h28, 32'h20, TAG + 32'h20, 1'b0, 32'd9, 32'd3);

    // Stall for 3 cycles: everything frozen.
    result = POP_BUF;
    stall  = 1'b1;
    tick(); snap("stall1", 32'h28, 32'h20, TAG + 32'h20, 1'b1, 32'd9, 32'd3);
    tick(); snap("stall2", 32'h28, 32'h20, TAG + 32'h20, 1'b1, 32'd9, 32'd3);
    tick(); snap("stall3", 32'h28, 32'h20, TAG + 32'h20, 1'b1, 32'd9, 32'd3);

    // Redirect during stall, low bits of target dropped.
    redirect    = 1'b1;
    redirect_pc = 32'h103;
    tick();
    redirect = 1'b0;
    stall    = 1'b0;
    #1 snap("redir", 32'h100, 32'h0, 32'h0, 1'b0, 32'd9, 32'd3);
    tick(); snap("redir_emit", 32'h104, 32'h100, TAG + 32'h100, 1'b1, 32'd9, 32'd4);

    // PC wrap at the top of the address space.
    redirect    = 1'b1;
    redirect_pc = 32'hFFFF_FFF8;
    tick();
    redirect = 1'b0;
    #1 snap("wrap_fill", 32'hFFFF_FFF8, 32'h0, 32'h0, 1'b0, 32'd9, 32'd4);
    tick(); snap("wrap1", 32'hFFFF_FFFC, 32'hFFFF_FFF8, 32'h0FFF_FFF8, 1'b1, 32'd9, 32'd5);
    tick(); snap("wrap2", 32'h0, 32'hFFFF_FFFC, 32'h0FFF_FFFC, 1'b1, 32'd10, 32'd5);
    tick(); snap("wrap3", 32'h4, 32'h0, TAG, 1'b1, 32'd11, 32'd5);

    // Asynchronous reset mid-cycle with B valid.
    #1 resetn = 1'b0;
    #1;
    chk("arst.imem_addr", imem_addr, 32'h0);
    snap("arst", 32'h0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0);
    tick();
    resetn = 1'b1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
